// File: rtl/fg_pkg.sv
// fg_pkg: shared widths, generator mode codes, step record and sequencer states
package fg_pkg;
  localparam int MODE_W = 3;
  localparam int DW = 16;
  typedef enum logic [MODE_W-1:0] {
    FG_OFF, FG_SINE, FG_SQUARE, FG_TRIANGLE, FG_SAWTOOTH, FG_RAMP_DN, FG_NOISE, FG_DC
  } fg_mode_e;
  typedef struct packed {
    logic [MODE_W-1:0] mode;
    logic [DW-1:0]     dwell;
  } fg_step_t;
  typedef enum logic {IDLE, RUN} fg_state_e;
  localparam fg_step_t STEP_RST = '{mode: '0, dwell: DW'(1)};
endpackage

// File: rtl/fg_step_table.sv
// fg_step_table: step register file, one sync write port, one async read port
module fg_step_table import fg_pkg::*; #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n_i,
  input  logic          we_i,
  input  logic [AW-1:0] wa_i,
  input  fg_step_t      wd_i,
  input  logic [AW-1:0] ra_i,
  output fg_step_t      rd_o
);
  fg_step_t mem_q [DEPTH];
  always_ff @(posedge clk or negedge rst_n_i)
    if (!rst_n_i) for (int i = 0; i < DEPTH; i++) mem_q[i] <= STEP_RST;
    else if (we_i) mem_q[wa_i] <= wd_i;
  assign rd_o = mem_q[ra_i];
endmodule

// File: rtl/fg_sequencer.sv
// fg_sequencer: plays (mode, dwell) steps onto the functionGenerator status input
module fg_sequencer import fg_pkg::*; #(
  parameter int                DEPTH     = 8,
  parameter logic [MODE_W-1:0] IDLE_MODE = FG_OFF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [AW:0]       num_steps,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [MODE_W-1:0] wr_mode,
  input  logic [DW-1:0]     wr_dwell,
  output logic [MODE_W-1:0] status,
  output logic              busy,
  output logic [AW-1:0]     step_idx,
  output logic              step_pulse,
  output logic              done,
  output logic              wr_err
);
  fg_state_e         state_q, state_d;
  logic [MODE_W-1:0] status_q, status_d;
  logic [DW-1:0]     cnt_q, cnt_d, rd_dwell;
  logic [AW-1:0]     idx_q, idx_d, rd_addr;
  logic [AW:0]       n_q, n_d;
  logic              busy_q, busy_d, pulse_q, pulse_d, done_q, done_d, werr_q, werr_d;
  logic              last;
  fg_step_t          rd_step, wr_step;
  assign wr_step = '{mode: wr_mode, dwell: wr_dwell};
  fg_step_table #(.DEPTH(DEPTH)) u_table (
    .clk     (clk),
    .rst_n_i (rst),
    .we_i    (wr_en && state_q == IDLE),
    .wa_i    (wr_addr),
    .wd_i    (wr_step),
    .ra_i    (rd_addr),
    .rd_o    (rd_step)
  );
  // the single read port always looks at the entry that would be entered next
  assign last     = ({1'b0, idx_q} + (AW+1)'(1)) == n_q;
  assign rd_addr  = (state_q == IDLE || last) ? '0 : idx_q + 1'b1;
  assign rd_dwell = (rd_step.dwell == '0) ? DW'(1) : rd_step.dwell;
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    n_d      = n_q;
    busy_d   = busy_q;
    pulse_d  = 1'b0;
    done_d   = 1'b0;
    werr_d   = wr_en && state_q == RUN;
    if (state_q == IDLE) begin
      if (start && num_steps != '0) begin
        state_d  = RUN;
        busy_d   = 1'b1;
        n_d      = (num_steps > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_steps;
        status_d = rd_step.mode;
        cnt_d    = rd_dwell;
        idx_d    = '0;
        pulse_d  = 1'b1;
      end
    end else if (stop) begin
      state_d  = IDLE;
      status_d = IDLE_MODE;
      busy_d   = 1'b0;
      cnt_d    = '0;
    end else if (cnt_q > DW'(1)) begin
      cnt_d = cnt_q - 1'b1;
    end else if (!last || loop_en) begin
      status_d = rd_step.mode;
      cnt_d    = rd_dwell;
      idx_d    = rd_addr;
      pulse_d  = 1'b1;
    end else begin
      state_d  = IDLE;
      status_d = IDLE_MODE;
      busy_d   = 1'b0;
      done_d   = 1'b1;
      cnt_d    = '0;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q  <= IDLE;
      status_q <= IDLE_MODE;
      cnt_q    <= '0;
      idx_q    <= '0;
      n_q      <= '0;
      busy_q   <= 1'b0;
      pulse_q  <= 1'b0;
      done_q   <= 1'b0;
      werr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      n_q      <= n_d;
      busy_q   <= busy_d;
      pulse_q  <= pulse_d;
      done_q   <= done_d;
      werr_q   <= werr_d;
    end
  assign status     = status_q;
  assign busy       = busy_q;
  assign step_idx   = idx_q;
  assign step_pulse = pulse_q;
  assign done       = done_q;
  assign wr_err     = werr_q;
endmodule

// File: tb/tb_fg_sequencer.sv
// tb_fg_sequencer: directed and random playback checked against an expanded-table model
module tb_fg_sequencer;
  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, stop = 1'b0, loop_en = 1'b0, wr_en = 1'b0;
  logic [3:0]  num_steps = '0;
  logic [2:0]  wr_addr = '0, wr_mode = '0;
  logic [15:0] wr_dwell = '0;
  logic [2:0]  status, step_idx;
  logic        busy, step_pulse, done, wr_err;
  int tests = 0, fails = 0;
  int m_mode[8], m_dw[8];
  int em[$], ep[$], ei[$];
  always #5 clk = ~clk;
  fg_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
    .num_steps(num_steps), .wr_en(wr_en), .wr_addr(wr_addr), .wr_mode(wr_mode),
    .wr_dwell(wr_dwell), .status(status), .busy(busy), .step_idx(step_idx),
    .step_pulse(step_pulse), .done(done), .wr_err(wr_err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      m_mode[i] = 0;
      m_dw[i] = 1;
    end
  endfunction
  // one entry per RUN cycle: mode shown, whether it is a step entry, step index
  function automatic void build(input int n_req);
    int n = (n_req > 8) ? 8 : n_req;
    em.delete(); ep.delete(); ei.delete();
    for (int s = 0; s < n; s++) begin
      int d = (m_dw[s] == 0) ? 1 : m_dw[s];
      for (int k = 0; k < d; k++) begin
        em.push_back(m_mode[s]);
        ep.push_back(k == 0);
        ei.push_back(s);
      end
    end
  endfunction
  task automatic wr(input int a, input int m, input int d);
    wr_en = 1'b1; wr_addr = a[2:0]; wr_mode = m[2:0]; wr_dwell = d[15:0];
    @(negedge clk);
    wr_en = 1'b0;
    m_mode[a] = m;
    m_dw[a] = d;
    chk("wr_err_idle", wr_err, 0);
  endtask
  task automatic go(input int n_req, input bit lp);
    num_steps = n_req[3:0]; loop_en = lp; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic chk_pos(input string tag, input int p);
    int q = p % em.size();
    chk($sformatf("%s_status@%0d", tag, p), status, em[q]);
    chk($sformatf("%s_busy@%0d", tag, p), busy, 1);
    chk($sformatf("%s_pulse@%0d", tag, p), step_pulse, ep[q]);
    chk($sformatf("%s_idx@%0d", tag, p), step_idx, ei[q]);
    chk($sformatf("%s_done@%0d", tag, p), done, 0);
  endtask
  task automatic chk_end(input string tag);
    chk({tag, "_end_status"}, status, 0);
    chk({tag, "_end_busy"}, busy, 0);
    chk({tag, "_end_done"}, done, 1);
    @(negedge clk);
    chk({tag, "_done_once"}, done, 0);
  endtask
  task automatic run_once(input string tag, input int n_req);
    build(n_req);
    go(n_req, 1'b0);
    for (int p = 0; p < em.size(); p++) begin
      chk_pos(tag, p);
      @(negedge clk);
    end
    chk_end(tag);
  endtask
  task automatic run_loop(input string tag, input int n_req, input int cycles);
    int p;
    build(n_req);
    go(n_req, 1'b1);
    for (p = 0; p < cycles; p++) begin
      chk_pos(tag, p);
      if (p == cycles - 1) loop_en = 1'b0;
      @(negedge clk);
    end
    while (p % em.size() != 0) begin
      chk_pos(tag, p);
      p++;
      @(negedge clk);
    end
    chk_end(tag);
  endtask
  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_status", status, 0);
    chk("rst_busy", busy, 0);
    chk("rst_idx", step_idx, 0);
    chk("rst_pulse", step_pulse, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_err", wr_err, 0);
    rst = 1'b1;
    @(negedge clk);
    wr(0, 1, 4); wr(1, 2, 2); wr(2, 3, 1);
    run_once("t1", 3);
    run_loop("t2", 3, 20);
    wr(0, 5, 0);
    run_once("t3", 1);
    wr(0, 1, 4);
    build(3);
    go(3, 1'b0);
    for (int p = 0; p < 3; p++) begin
      chk_pos("t4a", p);
      if (p == 2) stop = 1'b1;
      @(negedge clk);
    end
    stop = 1'b0;
    chk("t4a_status", status, 0);
    chk("t4a_busy", busy, 0);
    chk("t4a_done", done, 0);
    @(negedge clk);
    chk("t4a_done_after", done, 0);
    go(3, 1'b0);
    for (int p = 0; p < 7; p++) begin
      chk_pos("t4b", p);
      if (p == 6) stop = 1'b1;
      @(negedge clk);
    end
    stop = 1'b0;
    chk("t4b_status", status, 0);
    chk("t4b_busy", busy, 0);
    chk("t4b_done", done, 0);
    @(negedge clk);
    chk("t4b_done_after", done, 0);
    go(3, 1'b0);
    for (int p = 0; p < 7; p++) begin
      chk_pos("t5", p);
      if (p == 1) begin
        wr_en = 1'b1; wr_addr = 3'd1; wr_mode = 3'd7; wr_dwell = 16'd9;
      end
      if (p == 2) begin
        chk("t5_wr_err", wr_err, 1);
        wr_en = 1'b0;
      end
      if (p == 3) chk("t5_wr_err_once", wr_err, 0);
      @(negedge clk);
    end
    chk_end("t5");
    run_once("t5_table", 3);
    go(3, 1'b0);
    for (int p = 0; p < 5; p++) begin
      chk_pos("t6", p);
      @(negedge clk);
    end
    chk_pos("t6", 5);
    #2 rst = 1'b0;
    #1;
    chk("t6_async_status", status, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_idx", step_idx, 0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    run_once("t6_table", 8);
    go(0, 1'b0);
    chk("t6_zero_busy", busy, 0);
    chk("t6_zero_pulse", step_pulse, 0);
    @(negedge clk);
    chk("t6_zero_busy2", busy, 0);
    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < 8; a++) wr(a, $urandom_range(0, 7), $urandom_range(0, 4));
      run_once($sformatf("rnd%0d", r), $urandom_range(1, 15));
    end
    run_loop("rnd_loop", $urandom_range(1, 8), $urandom_range(10, 30));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fg_sequencer.md
Name: fg_sequencer

Overview:
- Programmable step scheduler that drives the 3-bit `status` (waveform-mode select) input of `functionGenerator`.
- Holds a small table of steps. Each step is a (mode, dwell) pair.
- On `start`, plays the steps in order, holding each mode for exactly `dwell` clock cycles. Can play once or loop.
- Sits between the host/config logic and `functionGenerator`. It replaces hand-driven mode changes with cycle-exact sequencing.

Parameters:
- DEPTH, 8: number of step table entries.
- DW, 16: dwell counter width, in clock cycles.
- MODE_W, 3: mode width; matches the generator `status` input.
- IDLE_MODE, 0: mode driven on `status` when not running.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted at 0).
- start  in  1  begin playback; sampled only in IDLE.
- stop  in  1  abort playback; sampled in RUN.
- loop_en  in  1  when 1, wrap from the last step back to step 0; sampled at every wrap.
- num_steps  in  4  number of active steps; latched at start.
- wr_en  in  1  table write strobe.
- wr_addr  in  3  table index.
- wr_mode  in  MODE_W  mode to store.
- wr_dwell  in  DW  dwell to store.
- status  out  MODE_W  mode select to `functionGenerator`.
- busy  out  1  high while in RUN.
- step_idx  out  3  index of the current step.
- step_pulse  out  1  one-cycle pulse on every step entry, including the first step.
- done  out  1  one-cycle pulse when a non-looping sequence completes.
- wr_err  out  1  one-cycle pulse when a write is rejected.

Behaviour:
- Reset (`rst`=0, asynchronous): the following are cleared.
  - State = IDLE.
  - `status` = IDLE_MODE.
  - `busy`, `step_pulse`, `done`, `wr_err` = 0.
  - `step_idx` = 0.
  - Dwell counter = 0.
  - Every table entry = (mode 0, dwell 1).
- Reset mid-run: `status` returns to IDLE_MODE immediately, without waiting for a clock edge.
- All outputs are registered.
- Table writes:
  - Accepted only in IDLE: at the edge, `mem[wr_addr]` ← {wr_mode, wr_dwell}.
  - A write while in RUN is dropped, and `wr_err`=1 for one cycle.
- Dwell of 0 is treated as 1.
- States: IDLE and RUN.
- IDLE → RUN: start=1 and num_steps≠0, sampled at an edge. At that same edge:
  - `status` ← mem[0].mode.
  - Counter ← max(mem[0].dwell, 1).
  - `step_idx` ← 0, `step_pulse` ← 1, `busy` ← 1.
  - num_steps is latched, clamped to DEPTH if larger.
- start with num_steps=0: ignored; the block stays in IDLE.
- RUN, each cycle:
  - If counter > 1: counter decrements.
  - If counter == 1 and this is not the last step: advance to step i+1. `status`, counter and `step_idx` load from that entry, and `step_pulse`=1.
  - If counter == 1 on the last step with loop_en=1: advance to step 0, with the same loads as above.
  - If counter == 1 on the last step with loop_en=0: go to IDLE. `status` ← IDLE_MODE, `busy` ← 0, `done` ← 1 for one cycle.
- Net timing: each step's mode appears on `status` for exactly max(dwell,1) consecutive cycles. There are no gap cycles between steps.
- stop=1 in RUN: next edge goes to IDLE. `status` ← IDLE_MODE, `busy` ← 0. `done` does not pulse.
  - stop has priority over a step advance or completion in the same cycle.
- start while in RUN: ignored. Re-trigger requires a return to IDLE.
- stop while in IDLE: ignored.
- num_steps and wr_* changes during RUN do not affect the running sequence.

Decomposition:
- Package `fg_pkg`:
  - MODE_W and DW constants.
  - The mode enumeration shared with `functionGenerator`.
  - Typedef `fg_step_t` = {mode, dwell}.
  - State enum {IDLE, RUN}.
- Sub-module `fg_step_table`: DEPTH-entry register file with one synchronous write port and one asynchronous read port, and asynchronous clear on `rst`.
- Sequencing FSM and dwell counter stay in the top level.

Test Plan:
1. Reset and write check: hold rst=0, then release. Write mem[0..2] = (1,4), (2,2), (3,1); num_steps=3, loop_en=0; pulse start.
   - Required: `status` = 1,1,1,1, 2,2, 3, then 0.
   - `step_pulse` at the 1st, 5th and 7th RUN cycles.
   - `done` pulses on the cycle `status` returns to 0.
   - `busy` is high for exactly 7 cycles.
2. Looping: same table with loop_en=1, run 20 cycles.
   - Required: period-7 pattern 1111223 repeats and `done` never pulses.
   - Then clear loop_en: `done` pulses after the next step-2 cycle.
3. Dwell 0: mem[0] = (5,0), num_steps=1.
   - Required: `status`=5 for exactly one cycle, then `done`.
4. Stop mid-step and stop/advance collision:
   - Assert stop in the 3rd cycle of step 0: next edge gives `status`=0, `busy`=0, and `done` stays 0.
   - Assert stop together with the final counter==1 cycle: `done` stays 0.
5. Write during RUN: issue wr_en with wr_addr=1 mid-run.
   - Required: `wr_err` pulses once; after completion, mem[1] still reads (2,2).
6. Async reset mid-run: drop rst at a non-edge time during step 1.
   - Required: `status`=0 and `busy`=0 immediately, and table contents read back as (0,1).
   - start with num_steps=0 is then ignored: `busy` stays 0.
